// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 codes, FSM states,
// rejection causes and the request classifier.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISALIGN = 2'd1,
        RANGE    = 2'd2,
        ILLEGAL  = 2'd3
    } lsu_cause_e;

    // Priority is illegal > misaligned > out of range; funct3[1:0] encodes size.
    function automatic lsu_cause_e classify(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] offset,
                                            input logic       out_of_range);
        logic illegal;
        illegal = we ? (funct3 > F3_W)
                     : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        if (illegal)
            return ILLEGAL;
        else if ((funct3[1:0] == 2'b01 && offset[0]) ||
                 (funct3[1:0] == 2'b10 && offset != 2'b00))
            return MISALIGN;
        else if (out_of_range)
            return RANGE;
        else
            return NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension
// and sub-word store merge into a previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        byte_sel     = word_i[7:0];
        half_sel     = offset_i[1] ? word_i[31:16] : word_i[15:0];
        load_data_o  = word_i;
        store_word_o = wdata_i;

        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase

        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            default: load_data_o = word_i;
        endcase

        // Store merge keeps the untouched lanes of the read word.
        case (funct3_i)
            F3_B: begin
                store_word_o = word_i;
                case (offset_i)
                    2'd0:    store_word_o[7:0]   = wdata_i[7:0];
                    2'd1:    store_word_o[15:8]  = wdata_i[7:0];
                    2'd2:    store_word_o[23:16] = wdata_i[7:0];
                    default: store_word_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                store_word_o = word_i;
                if (offset_i[1])
                    store_word_o[31:16] = wdata_i[15:0];
                else
                    store_word_o[15:0]  = wdata_i[15:0];
            end
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_initiator.sv
// Single-outstanding RV32I load/store unit driving a word-wide memory port
// with combinational read and synchronous write; sub-word stores use RMW.
module lsu_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 2048
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err,
    output logic [1:0]        o_resp_cause,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    localparam int WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W:0] WORD_LIMIT = (WIDX_W + 1)'(MEM_WORDS);

    lsu_state_e        state_q,  state_d;
    lsu_cause_e        cause_q,  cause_d;
    logic              we_q,     we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic [31:0]       merged_q, merged_d;

    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        req_oor;
    lsu_cause_e  req_cause;

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .offset_i     (addr_q[1:0]),
        .word_i       (i_mem_rdata),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    assign req_oor   = {1'b0, i_req_addr[ADDR_W-1:2]} >= WORD_LIMIT;
    assign req_cause = classify(i_req_we, i_req_funct3, i_req_addr[1:0], req_oor);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        merged_d = merged_q;

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    we_d     = i_req_we;
                    funct3_d = i_req_funct3;
                    addr_d   = i_req_addr;
                    wdata_d  = i_req_wdata;
                    cause_d  = req_cause;
                    rdata_d  = '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cause_q != NONE) begin
                    state_d = RESP;
                end else if (!we_q) begin
                    rdata_d = load_data;
                    state_d = RESP;
                end else if (funct3_q == F3_W) begin
                    state_d = RESP;
                end else begin
                    merged_d = store_word;
                    state_d  = WRITE;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (i_reset) begin
            state_q  <= IDLE;
            cause_q  <= NONE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
        end
    end

    logic access_ok;
    logic sw_write;
    logic in_write;
    logic in_resp;

    assign access_ok = (state_q == ACCESS) && (cause_q == NONE);
    assign sw_write  = access_ok && we_q && (funct3_q == F3_W);
    assign in_write  = (state_q == WRITE);
    assign in_resp   = (state_q == RESP);

    // Write enable is gated by reset so an interrupted store never lands.
    assign o_mem_wren   = ~i_reset & (sw_write | in_write);
    assign o_mem_addr   = (access_ok || in_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign o_mem_wdata  = sw_write ? wdata_q : (in_write ? merged_q : '0);

    assign o_req_ready  = (state_q == IDLE);
    assign o_resp_valid = in_resp;
    assign o_resp_rdata = in_resp ? rdata_q : '0;
    assign o_resp_err   = in_resp && (cause_q != NONE);
    assign o_resp_cause = in_resp ? cause_q : NONE;

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
Load/store unit on the CPU side of the word-addressed data memory. It accepts one RV32I load or store request at a time and translates it into word-wide accesses on the memory port. The memory port has combinational read, synchronous write and a single word write-enable. Sub-word stores (SB/SH) are done as read-modify-write. Loads are byte/half extracted and sign- or zero-extended. Illegal, misaligned or out-of-range requests are rejected without touching memory.

Parameters:
ADDR_W, 32, byte-address width of request and memory ports
MEM_WORDS, 2048, number of implemented 32-bit words; word index >= MEM_WORDS is out of range

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_req_valid  in  1  request present
o_req_ready  out  1  high only in IDLE; request accepted when valid&ready at a rising edge
i_req_we  in  1  1 = store, 0 = load
i_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
i_req_addr  in  ADDR_W  byte address
i_req_wdata  in  32  store data, right-aligned
o_resp_valid  out  1  one-cycle completion pulse; no back-pressure
o_resp_rdata  out  32  extended load data; 0 for stores and errors
o_resp_err  out  1  request rejected
o_resp_cause  out  2  0 none, 1 misaligned, 2 out of range, 3 illegal funct3
o_mem_addr  out  ADDR_W  word-aligned byte address {addr[ADDR_W-1:2],2'b00}
o_mem_wdata  out  32  full word to write
o_mem_wren  out  1  word write enable
i_mem_rdata  in  32  combinational read data of o_mem_addr

Behaviour:
- FSM states: IDLE, ACCESS, WRITE, RESP. The request is latched on acceptance. Requests while busy are ignored (ready=0).
- IDLE -> ACCESS on valid&ready. In the acceptance cycle, classify the request and register the cause.
- Cause priority is illegal > misaligned > range:
  - Illegal funct3: loads 011/110/111; stores any funct3 > 010.
  - Misaligned: H with addr[0]=1; W with addr[1:0]!=0.
  - Out of range: addr[ADDR_W-1:2] >= MEM_WORDS.
- ACCESS:
  - Error: no memory activity, go to RESP.
  - Load: sample i_mem_rdata and extract the byte (addr[1:0]) or half (addr[1]). Sign-extend for LB/LH, zero-extend for LBU/LHU, pass LW through. Register the result, go to RESP.
  - SW: o_mem_wren=1, o_mem_wdata=req wdata, go to RESP.
  - SB/SH: capture i_mem_rdata, merge wdata[7:0]/[15:0] into the addressed lane, go to WRITE.
- WRITE: o_mem_wren=1, o_mem_wdata=merged word, go to RESP.
- RESP: o_resp_valid=1 with registered rdata/err/cause, then go to IDLE. The next request can be accepted on the following cycle.
- Latency from the acceptance edge T: loads/SW/errors respond at T+2; SB/SH respond at T+3.
- o_mem_addr is held stable from ACCESS through WRITE and is 0 in IDLE/RESP. o_mem_wren is 0 in all other states and cases.
- Reset (synchronous): state=IDLE; o_resp_*=0, o_mem_*=0, o_req_ready=1 the cycle after. o_mem_wren is gated by ~i_reset, so reset during ACCESS or WRITE drops the pending write and memory stays unchanged.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - lsu_state_e {IDLE, ACCESS, WRITE, RESP}.
  - lsu_cause_e {NONE, MISALIGN, RANGE, ILLEGAL}.
- One combinational sub-module lsu_align: load extract/extend and store lane merge, given funct3, addr[1:0], word and wdata.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF -> at T+1 o_mem_wren=1, o_mem_addr=0x10, o_mem_wdata=0xDEADBEEF; T+2 resp_valid, err=0, rdata=0.
- Follow-on loads from that word:
  - LB 0x13 -> 0xFFFFFFDE
  - LBU 0x13 -> 0x000000DE
  - LH 0x12 -> 0xFFFFDEAD
  - LHU 0x10 -> 0x0000BEEF
  - LW 0x10 -> 0xDEADBEEF
  - all respond at T+2.
- SB 0x11 data 0x12345677 -> T+1 read (wren=0), T+2 wren=1 wdata=0xDEAD77EF, T+3 resp; then SH 0x12 data 0x0000CAFE -> word 0xCAFE77EF.
- Error cases; each responds at T+2 with wren never asserted, rdata=0:
  - LW 0x12 -> err=1, cause=1.
  - LW 0x2000 (MEM_WORDS=2048) -> cause=2.
  - load funct3 011 -> cause=3.
  - SH 0x13 funct3 111 -> cause=3 (illegal wins).
- Back-to-back valid held high: first request accepted, ready low for 2/3 cycles, second request accepted only in the cycle after resp_valid; both complete correctly.
- SB 0x20 with i_reset pulsed during the WRITE cycle -> wren stays 0, memory word unchanged, no resp_valid, ready=1 the next cycle.
